regfile_access_arbiter: RTL and testbench

- Sequences and shares one 4x8 single-port register file among NUM_REQ requesters.
- Each requester issues read or write transactions over a valid/ready handshake.
- The block arbitrates round-robin and drives the register file's write/read ports.
- It returns a one-cycle response (read data, or write echo) to the granted requester.

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_access_arbiter_if.sv | 51 +++++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/regfile_access_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants, FSM state type and sizing helper for the
//            register-file access arbiter slice.
// Contents : DEFAULT_WIDTH / DEFAULT_ADDR / DEFAULT_DEPTH  register-file shape
//            state_t                                       arbiter FSM states
//            grant_width()                                 grant-index width
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_ADDR  = 2;
  localparam int DEFAULT_DEPTH = 1 << DEFAULT_ADDR;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Grant-index width for n requesters; never below one bit.
  function automatic int grant_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_access_arbiter_if.sv
// ============================================================================
// Module   : regfile_access_arbiter_if
// Purpose  : Requester-side handshake bus plus register-file port bundle.
// Modports : slave  - the arbiter (consumes requests, drives the RF ports)
//            master - requesters and the register file model
// Signals  : req_valid/req_we/req_addr/req_wdata  packed per-requester request
//            req_ready/rsp_valid                  one-hot pulses back
//            rsp_rdata                            response data
//            rf_w_en/rf_w_addr/rf_w_data          RF write port
//            rf_r_en/rf_r_addr/rf_r_data          RF read port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_access_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ADDR    = DEFAULT_ADDR
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*ADDR-1:0]  req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_rdata;
  logic                     rf_w_en;
  logic [ADDR-1:0]          rf_w_addr;
  logic [WIDTH-1:0]         rf_w_data;
  logic                     rf_r_en;
  logic [ADDR-1:0]          rf_r_addr;
  logic [WIDTH-1:0]         rf_r_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rf_r_data,
    output req_ready, rsp_valid, rsp_rdata,
           rf_w_en, rf_w_addr, rf_w_data, rf_r_en, rf_r_addr
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rf_r_data,
    input  req_ready, rsp_valid, rsp_rdata,
           rf_w_en, rf_w_addr, rf_w_data, rf_r_en, rf_r_addr
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. The search starts at ptr and
//            wraps upward; the first requesting index wins.
// Ports    : req       [NUM_REQ] request vector
//            ptr       [GW]      highest-priority index
//            grant     [NUM_REQ] one-hot winner
//            grant_idx [GW]      binary winner index
//            any                 at least one request present
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      grant_idx,
  output logic               any
);

  logic [GW:0]   w_sum;
  logic [GW-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr < NUM_REQ always, so one conditional subtract performs the wrap.
      w_sum = {1'b0, ptr} + (GW+1)'(i);
      if (w_sum >= (GW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (GW+1)'(NUM_REQ);
      end
      w_idx = w_sum[GW-1:0];
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_access_arbiter.sv
// ============================================================================
// Module   : regfile_access_arbiter
// Purpose  : Shares one single-port register file among NUM_REQ requesters.
//            Each transaction runs IDLE -> ACCESS -> RESP (3 cycles): the
//            winner is captured in IDLE, gets req_ready and the RF access in
//            ACCESS, and a one-cycle rsp_valid with data in RESP.
// Ports    : clk, rst (asynchronous, active-high)
//            bus  (regfile_access_arbiter_if.slave) requests, responses, RF
//            busy high during ACCESS and RESP
// Options  : REGFILE_ARB_FIXED_PRIO_EN - lowest index always wins; the
//            round-robin pointer is removed. Default build is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_access_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ADDR    = DEFAULT_ADDR,
  parameter int GW      = grant_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_access_arbiter_if.slave   bus,
  output logic                      busy
);

  state_t               r_state;
  logic [GW-1:0]        r_grant;
  logic                 r_we;
  logic [ADDR-1:0]      r_addr;
  logic [WIDTH-1:0]     r_wdata;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [WIDTH-1:0]     r_rsp_rdata;
  logic                 r_w_en;
  logic                 r_r_en;
  logic                 r_busy;

  logic [GW-1:0]        w_ptr;
  logic [NUM_REQ-1:0]   w_gnt_onehot;
  logic [GW-1:0]        w_gnt_idx;
  logic                 w_any;
  logic [ADDR-1:0]      w_addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]     w_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = bus.req_addr[gi*ADDR +: ADDR];
    assign w_wdata_arr[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
  end

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  // Pointer pinned to 0 turns the round-robin search into lowest-index-wins.
  assign w_ptr = '0;
`else
  logic [GW-1:0] r_rr_ptr;
  assign w_ptr = r_rr_ptr;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .ptr       (w_ptr),
    .grant     (w_gnt_onehot),
    .grant_idx (w_gnt_idx),
    .any       (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_w_en      <= 1'b0;
      r_r_en      <= 1'b0;
      r_busy      <= 1'b0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            // Capture the winner and pre-load the ACCESS-cycle outputs so
            // ready and the RF enables are registered.
            r_grant     <= w_gnt_idx;
            r_we        <= bus.req_we[w_gnt_idx];
            r_addr      <= w_addr_arr[w_gnt_idx];
            r_wdata     <= w_wdata_arr[w_gnt_idx];
            r_req_ready <= w_gnt_onehot;
            r_w_en      <= bus.req_we[w_gnt_idx];
            r_r_en      <= ~bus.req_we[w_gnt_idx];
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          // rf_r_data is only sampled here, while the read port is enabled.
          r_rsp_rdata <= r_we ? r_wdata : bus.rf_r_data;
          r_rsp_valid <= NUM_REQ'(1) << r_grant;
          r_req_ready <= '0;
          r_w_en      <= 1'b0;
          r_r_en      <= 1'b0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
          r_rr_ptr    <= (r_grant == GW'(NUM_REQ-1)) ? '0 : r_grant + GW'(1);
`endif
          r_state     <= RESP;
        end
        RESP: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rf_w_en   = r_w_en;
  assign bus.rf_w_addr = r_addr;
  assign bus.rf_w_data = r_wdata;
  assign bus.rf_r_en   = r_r_en;
  assign bus.rf_r_addr = r_addr;
  assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_arbiter.sv
// ============================================================================
// Module   : tb_regfile_access_arbiter
// Purpose  : Self-checking bench for regfile_access_arbiter. A transaction
//            model (pending requests, priority pointer, memory image) predicts
//            the winner, RF access and response of each transaction.
// Options  : honours REGFILE_ARB_FIXED_PRIO_EN for the expected grant order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_access_arbiter;

  localparam int NREQ = 4;

  logic clk;
  logic rst;
  logic busy;
  logic [7:0] rf_mem [4] = '{default: 8'h00};

  regfile_access_arbiter_if #(.NUM_REQ(NREQ), .WIDTH(8), .ADDR(2)) bus ();

  regfile_access_arbiter #(.NUM_REQ(NREQ), .WIDTH(8), .ADDR(2), .GW(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Register file: combinational read, high-Z when not enabled.
  always @(posedge clk) if (bus.rf_w_en) rf_mem[bus.rf_w_addr] <= bus.rf_w_data;
  assign bus.rf_r_data = bus.rf_r_en ? rf_mem[bus.rf_r_addr] : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit   [3:0] pend;
  logic       m_we   [NREQ];
  logic [1:0] m_addr [NREQ];
  logic [7:0] m_wd   [NREQ];
  logic [7:0] ref_mem [4];
  int         m_ptr;
  int         n_checks;
  int         n_fail;

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = pend[i];
      bus.req_we[i]          = m_we[i];
      bus.req_addr[i*2 +: 2] = m_addr[i];
      bus.req_wdata[i*8 +: 8] = m_wd[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [1:0] a, input logic [7:0] wd);
    pend[i] = 1'b1; m_we[i] = we; m_addr[i] = a; m_wd[i] = wd;
  endtask

  // Runs one transaction from an IDLE negedge to the next IDLE negedge.
  task automatic do_txn(input bit refill, output int g_obs, output logic [7:0] d_obs);
    int w;
    logic [3:0] oh;
    logic [7:0] exp_d;
    logic we;
    logic [1:0] a;
    logic [7:0] wd;
    g_obs = -1;
    d_obs = 8'h00;
    w = pick();
    if (w < 0) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_no_req: busy=%b req_ready=%b, want 0/0000", busy, bus.req_ready);
      end
      return;
    end
    oh = 4'b0001 << w;
    we = m_we[w]; a = m_addr[w]; wd = m_wd[w];
    exp_d = we ? wd : ref_mem[a];
    @(posedge clk); @(negedge clk);
    for (int i = NREQ-1; i >= 0; i--) if (bus.req_ready[i]) g_obs = i;
    n_checks++;
    if (bus.req_ready !== oh) begin
      n_fail++; $display("FAIL access_ready: got %b want %b", bus.req_ready, oh);
    end
    n_checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL access_status: busy=%b rsp_valid=%b want 1/0000", busy, bus.rsp_valid);
    end
    n_checks++;
    if (we) begin
      if ({bus.rf_w_en, bus.rf_r_en, bus.rf_w_addr, bus.rf_w_data} !== {1'b1, 1'b0, a, wd}) begin
        n_fail++;
        $display("FAIL access_write: w_en=%b r_en=%b addr=%0d data=%h want 1 0 %0d %h",
                 bus.rf_w_en, bus.rf_r_en, bus.rf_w_addr, bus.rf_w_data, a, wd);
      end
    end else begin
      if ({bus.rf_w_en, bus.rf_r_en, bus.rf_r_addr} !== {1'b0, 1'b1, a}) begin
        n_fail++;
        $display("FAIL access_read: w_en=%b r_en=%b addr=%0d want 0 1 %0d",
                 bus.rf_w_en, bus.rf_r_en, bus.rf_r_addr, a);
      end
    end
    if (!refill) pend[w] = 1'b0;
    drive();
    if (we) ref_mem[a] = wd;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
    m_ptr = (w + 1) % NREQ;
`endif
    @(posedge clk); @(negedge clk);
    d_obs = bus.rsp_rdata;
    n_checks++;
    if (bus.rsp_valid !== oh || bus.rsp_rdata !== exp_d) begin
      n_fail++;
      $display("FAIL resp: rsp_valid=%b rsp_rdata=%h want %b %h", bus.rsp_valid, bus.rsp_rdata, oh, exp_d);
    end
    n_checks++;
    if (busy !== 1'b1 || bus.req_ready !== 4'b0000 || bus.rf_w_en !== 1'b0 || bus.rf_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_status: busy=%b ready=%b w_en=%b r_en=%b want 1 0000 0 0",
               busy, bus.req_ready, bus.rf_w_en, bus.rf_r_en);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.rsp_rdata !== exp_d) begin
      n_fail++;
      $display("FAIL idle_after: busy=%b rsp_valid=%b rdata=%h want 0 0000 %h",
               busy, bus.rsp_valid, bus.rsp_rdata, exp_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin m_we[i] = 1'b0; m_addr[i] = 2'd0; m_wd[i] = 8'h00; end
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
    m_ptr = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, busy} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_resp: ready=%b rsp_valid=%b rdata=%h busy=%b want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, busy);
    end
    n_checks++;
    if ({bus.rf_w_en, bus.rf_r_en, bus.rf_w_addr, bus.rf_r_addr, bus.rf_w_data} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_rf: w_en=%b r_en=%b waddr=%0d raddr=%0d wdata=%h want all 0",
               bus.rf_w_en, bus.rf_r_en, bus.rf_w_addr, bus.rf_r_addr, bus.rf_w_data);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_write_read();
    int g; logic [7:0] d;
    set_req(0, 1'b1, 2'd2, 8'hA5); drive();
    do_txn(1'b0, g, d);
    n_checks++;
    if (g !== 0 || d !== 8'hA5) begin
      n_fail++; $display("FAIL wr_single: grant=%0d data=%h want 0 a5", g, d);
    end
    set_req(0, 1'b0, 2'd2, 8'h00); drive();
    do_txn(1'b0, g, d);
    n_checks++;
    if (g !== 0 || d !== 8'hA5) begin
      n_fail++; $display("FAIL rd_single: grant=%0d data=%h want 0 a5", g, d);
    end
  endtask

  task automatic test_coherence();
    int g1, g2; logic [7:0] d1, d2;
    set_req(1, 1'b1, 2'd3, 8'h5C);
    set_req(2, 1'b0, 2'd3, 8'h00);
    drive();
    do_txn(1'b0, g1, d1);
    do_txn(1'b0, g2, d2);
    n_checks++;
    if (g1 !== 1 || g2 !== 2 || d2 !== 8'h5C) begin
      n_fail++; $display("FAIL coherence: grants=%0d,%0d rdata=%h want 1,2 5c", g1, g2, d2);
    end
  endtask

  task automatic test_round_robin();
    int g; logic [7:0] d;
    int exp_g [5];
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
    if (m_ptr != 0) begin
      set_req(NREQ-1, 1'b0, 2'd0, 8'h00); drive();
      do_txn(1'b0, g, d);
    end
`endif
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 2'(i), 8'h00);
    drive();
    for (int t = 0; t < 5; t++) begin
      do_txn(1'b1, g, d);
      n_checks++;
      if (g !== exp_g[t]) begin
        n_fail++; $display("FAIL rr_order[%0d]: grant=%0d want %0d", t, g, exp_g[t]);
      end
    end
    pend = '0; drive();
  endtask

  task automatic test_skip_fairness();
    int g1, g2; logic [7:0] d;
    int e1, e2;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    e1 = 0; e2 = 3;
`else
    e1 = 3; e2 = 0;
    if (m_ptr != 1) begin
      set_req(0, 1'b0, 2'd0, 8'h00); drive();
      do_txn(1'b0, g1, d);
    end
`endif
    set_req(0, 1'b0, 2'd1, 8'h00);
    set_req(3, 1'b0, 2'd2, 8'h00);
    drive();
    do_txn(1'b0, g1, d);
    do_txn(1'b0, g2, d);
    n_checks++;
    if (g1 !== e1 || g2 !== e2) begin
      n_fail++; $display("FAIL skip_fair: grants=%0d,%0d want %0d,%0d", g1, g2, e1, e2);
    end
  endtask

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int g; logic [7:0] d;
    set_req(0, 1'b1, 2'd0, 8'h11);
    set_req(3, 1'b0, 2'd1, 8'h00);
    drive();
    for (int t = 0; t < 4; t++) begin
      do_txn(1'b1, g, d);
      n_checks++;
      if (g !== 0) begin
        n_fail++; $display("FAIL fixed_prio[%0d]: grant=%0d want 0", t, g);
      end
    end
    pend = '0; drive();
  endtask
`endif

  task automatic test_random();
    int g; logic [7:0] d;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
        else if (pend[i] && $urandom_range(7, 0) == 0)
          pend[i] = 1'b0;
      end
      if (pend == 4'b0000)
        set_req($urandom_range(3, 0), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                8'($urandom_range(255, 0)));
      drive();
      do_txn(1'b0, g, d);
    end
    pend = '0; drive();
  endtask

  task automatic test_reset_mid_access();
    int g; logic [7:0] d;
    logic [7:0] old;
    set_req(1, 1'b0, 2'd0, 8'h00); drive();
    do_txn(1'b0, g, d);
    old = ref_mem[1];
    set_req(2, 1'b1, 2'd1, ~old); drive();
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0100 || bus.rf_w_en !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: ready=%b w_en=%b want 0100 1", bus.req_ready, bus.rf_w_en);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, busy, bus.rf_w_en, bus.rf_r_en,
         bus.rf_w_addr, bus.rf_r_addr, bus.rf_w_data} !== 31'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: ready=%b rsp=%b rdata=%h busy=%b w_en=%b r_en=%b wdata=%h want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, busy, bus.rf_w_en, bus.rf_r_en, bus.rf_w_data);
    end
    pend = '0; drive();
    m_ptr = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_rsp[%0d]: rsp_valid=%b busy=%b want 0000 0", c, bus.rsp_valid, busy);
      end
    end
    set_req(0, 1'b0, 2'd1, 8'h00);
    for (int i = 1; i < NREQ; i++) set_req(i, 1'b0, 2'(i), 8'h00);
    drive();
    do_txn(1'b0, g, d);
    n_checks++;
    if (g !== 0 || d !== old) begin
      n_fail++; $display("FAIL abort_after: grant=%0d data=%h want 0 %h", g, d, old);
    end
    pend = '0; drive();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read();
    test_coherence();
    test_round_robin();
    test_skip_fairness();
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
